// File: rtl/bin_conv_mul_arbiter_pkg.sv
// Shared types and helpers for the bin_conv multiplier arbiter.
// BIN_CONV_MUL_ARB_SAT_EN widens the carried product so the saturation test can see the high bits.
package bin_conv_mul_pkg;
  localparam int A_W     = 15;
  localparam int B_W     = 5;
  localparam int P_W     = 16;
  localparam int FULL_W  = A_W + B_W;
  localparam int MAX_REQ = 8;
  localparam int TAG_W   = 3;

  // Without saturation the bits above P_W never reach the output, so they are not carried.
`ifdef BIN_CONV_MUL_ARB_SAT_EN
  localparam int STG_P_W = FULL_W;
`else
  localparam int STG_P_W = P_W;
`endif

  typedef struct packed {
    logic               vld;
    logic [TAG_W-1:0]   id;
    logic [A_W-1:0]     a;
    logic [B_W-1:0]     b;
    logic [STG_P_W-1:0] p;
  } mul_stage_t;

  function automatic logic [STG_P_W-1:0] mul_p(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    return STG_P_W'(FULL_W'(a) * FULL_W'(b));
  endfunction

  // Returns {found, index} of the first set request at or after ptr, wrapping at n.
  function automatic logic [TAG_W:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                             input logic [TAG_W-1:0] ptr, input int n);
    logic [TAG_W:0] res;
    int             idx;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx[TAG_W-1:0]]) res = {1'b1, idx[TAG_W-1:0]};
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/bin_conv_mul_arbiter_if.sv
// Requester-side bus of the shared multiplier: operand handshake, tagged response, busy.
interface bin_conv_mul_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]                        req_valid;
  logic [NUM_REQ-1:0]                        req_ready;
  logic [NUM_REQ*bin_conv_mul_pkg::A_W-1:0]  req_a;
  logic [NUM_REQ*bin_conv_mul_pkg::B_W-1:0]  req_b;
  logic [NUM_REQ-1:0]                        rsp_valid;
  logic [NUM_REQ-1:0]                        rsp_ready;
  logic [bin_conv_mul_pkg::P_W-1:0]          rsp_p;
  logic                                      busy;

  modport master (output req_valid, req_a, req_b, rsp_ready,
                  input  req_ready, rsp_valid, rsp_p, busy);
  modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_p, busy);
endinterface

// File: rtl/bin_conv_mul_arbiter_rr_arb.sv
// Round-robin picker: first active request from ptr upward, one-hot grant plus index.
module bin_conv_mul_rr_arb
  import bin_conv_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_idx,
  output logic               o_gnt_vld
);
  logic [TAG_W:0] w_pick;

  assign w_pick    = rr_pick(MAX_REQ'(i_req), TAG_W'(i_ptr), NUM_REQ);
  assign o_gnt_vld = i_en & w_pick[TAG_W];
  assign o_gnt_idx = ID_W'(w_pick[TAG_W-1:0]);
  assign o_gnt     = o_gnt_vld ? (NUM_REQ'(1) << o_gnt_idx) : '0;
endmodule

// File: rtl/bin_conv_mul_arbiter.sv
// One 15x5 multiplier shared by NUM_REQ lanes: RR grant, MUL_LAT-stage stallable pipe, tagged replies.
// Optional BIN_CONV_MUL_ARB_SAT_EN: saturate to 16'hFFFF and expose a sticky sat_flag.
module bin_conv_mul_arbiter
  import bin_conv_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int MUL_LAT = 3
)(
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  bin_conv_mul_arbiter_if.slave bus
`ifdef BIN_CONV_MUL_ARB_SAT_EN
  ,
  output logic                  sat_flag
`endif
);
  localparam int LAST = MUL_LAT - 1;

  mul_stage_t          r_stg [MUL_LAT];
  logic [ID_W-1:0]     r_ptr;
  mul_stage_t          w_last;
  logic [NUM_REQ-1:0]  w_rsp_vld;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_gnt_vld;
  logic                w_rsp_hs;
  logic                w_stall;
  logic                w_en;
  logic [A_W-1:0]      w_a;
  logic [B_W-1:0]      w_b;
  logic [P_W-1:0]      w_p;
  logic                w_busy;

  assign w_last = r_stg[LAST];

  always_comb begin
    w_rsp_vld = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_rsp_vld[i] = w_last.vld & (w_last.id == TAG_W'(i));
  end

  assign w_rsp_hs = |(w_rsp_vld & bus.rsp_ready);
  assign w_stall  = w_last.vld & ~w_rsp_hs;
  assign w_en     = ap_rst_n & ~w_stall;

  bin_conv_mul_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req     (bus.req_valid),
    .i_ptr     (r_ptr),
    .i_en      (w_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_a = bus.req_a[i*A_W +: A_W];
        w_b = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  // S0 registers operands; S1 does the multiply so it lands in the DSP's registered multiplier.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) r_stg[i] <= '0;
      r_ptr <= '0;
    end else if (!w_stall) begin
      r_stg[0].vld <= w_gnt_vld;
      r_stg[0].id  <= TAG_W'(w_gnt_idx);
      r_stg[0].a   <= w_a;
      r_stg[0].b   <= w_b;
      r_stg[0].p   <= (MUL_LAT == 1) ? mul_p(w_a, w_b) : '0;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_stg[i] <= r_stg[i-1];
        if (i == 1) r_stg[i].p <= mul_p(r_stg[0].a, r_stg[0].b);
      end
      if (w_gnt_vld)
        r_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

`ifdef BIN_CONV_MUL_ARB_SAT_EN
  logic w_sat;
  logic r_sat;

  assign w_sat = |w_last.p[FULL_W-1:P_W];
  assign w_p   = w_sat ? '1 : w_last.p[P_W-1:0];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)             r_sat <= 1'b0;
    else if (w_rsp_hs & w_sat) r_sat <= 1'b1;
  end

  assign sat_flag = r_sat;
`else
  assign w_p = w_last.p;
`endif

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) w_busy = w_busy | r_stg[i].vld;
  end

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = w_rsp_vld;
  assign bus.rsp_p     = w_last.vld ? w_p : '0;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_bin_conv_mul_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference.
module tb_bin_conv_mul_arbiter;
  import bin_conv_mul_pkg::*;
  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  bit   started = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bin_conv_mul_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef BIN_CONV_MUL_ARB_SAT_EN
  logic sat_flag;
  bin_conv_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus), .sat_flag(sat_flag));
`else
  bin_conv_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus));
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: transactions in grant order, each with the number of moving cycles left.
  typedef struct {
    int         id;
    logic [15:0] p;
    bit         sat;
    int         cnt;
  } ent_t;

  ent_t               q[$];
  ent_t               m_e;
  int                 m_ptr = 0;
  bit                 m_sat = 1'b0;
  bit                 m_out, m_stall, m_found;
  int                 m_gid, m_id, m_full;
  logic [NUM_REQ-1:0] m_rdy, m_vld;
  logic [15:0]        m_p;

  always @(negedge clk) begin
    m_out = 1'b0; m_stall = 1'b0; m_found = 1'b0; m_gid = 0;
    m_rdy = '0; m_vld = '0; m_p = '0;
    if (q.size() > 0 && q[0].cnt == 0) begin
      m_out   = 1'b1;
      m_vld   = NUM_REQ'(1) << q[0].id;
      m_p     = q[0].p;
      m_stall = !bus.rsp_ready[q[0].id];
    end
    if (rst_n === 1'b1 && !m_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        m_id = (m_ptr + k) % NUM_REQ;
        if (!m_found && bus.req_valid[m_id]) begin
          m_found = 1'b1;
          m_gid   = m_id;
          m_rdy   = NUM_REQ'(1) << m_id;
        end
      end
    end
    if (started) begin
      chk("req_ready", 32'(bus.req_ready), 32'(m_rdy));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_vld));
      chk("rsp_p",     32'(bus.rsp_p),     32'(m_p));
      chk("busy",      32'(bus.busy),      32'(q.size() > 0));
`ifdef BIN_CONV_MUL_ARB_SAT_EN
      chk("sat_flag",  32'(sat_flag),      32'(m_sat));
`endif
    end
    if (rst_n !== 1'b1) begin
      q.delete();
      m_ptr = 0;
      m_sat = 1'b0;
    end else if (!m_stall) begin
      if (m_out) begin
        if (q[0].sat) m_sat = 1'b1;
        void'(q.pop_front());
      end
      foreach (q[j]) q[j].cnt = q[j].cnt - 1;
      if (m_found) begin
        m_full = int'(bus.req_a[m_gid*A_W +: A_W]) * int'(bus.req_b[m_gid*B_W +: B_W]);
        m_e.id  = m_gid;
        m_e.sat = (m_full > 65535);
`ifdef BIN_CONV_MUL_ARB_SAT_EN
        m_e.p   = m_e.sat ? 16'hFFFF : 16'(m_full);
`else
        m_e.p   = 16'(m_full % 65536);
`endif
        m_e.cnt = MUL_LAT - 1;
        q.push_back(m_e);
        m_ptr = (m_gid + 1) % NUM_REQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[i*A_W +: A_W] = A_W'(a);
    bus.req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    step();
    started = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_busy",  32'(bus.busy),      32'h0);
    chk("rst_rsp_p", 32'(bus.rsp_p),     32'h0);
    step();
    rst_n = 1'b1;
    bus.req_valid = '0;

    // Single request: 1000*3
    set_op(0, 1000, 3);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    repeat (MUL_LAT - 1) step();
    @(negedge clk);
    chk("t1_vld", 32'(bus.rsp_valid), 32'h1);
    chk("t1_p",   32'(bus.rsp_p),     32'd3000);
    step();

    // All requesters continuously valid; ptr is 1 after the previous grant
    for (int i = 0; i < NUM_REQ; i++) set_op(i, i + 1, 2);
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_grant", 32'(bus.req_ready), 32'(1 << ((1 + k) % NUM_REQ)));
      if (k >= MUL_LAT)
        chk("t2_rsp", 32'(bus.rsp_valid), 32'(1 << ((1 + k - MUL_LAT) % NUM_REQ)));
      step();
    end
    bus.req_valid = '0;
    repeat (MUL_LAT + 1) step();

    // Overflowing product
    set_op(2, 32'h7FFF, 31);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("t3_grant", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = '0;
    repeat (MUL_LAT - 1) step();
    @(negedge clk);
    chk("t3_vld", 32'(bus.rsp_valid), 32'h4);
`ifdef BIN_CONV_MUL_ARB_SAT_EN
    chk("t3_p", 32'(bus.rsp_p), 32'hFFFF);
    step();
    @(negedge clk);
    chk("t3_sat", 32'(sat_flag), 32'h1);
`else
    chk("t3_p", 32'(bus.rsp_p), 32'h7FE1);
    step();
`endif

    // Stall: requester 1 withholds rsp_ready while its three products are in flight
    bus.rsp_ready = 4'b1101;
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      set_op(1, 5 + k, 6);
      step();
    end
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_ready", 32'(bus.req_ready), 32'h0);
      chk("t4_vld",   32'(bus.rsp_valid), 32'h2);
      chk("t4_p",     32'(bus.rsp_p),     32'd30);
      step();
    end
    bus.rsp_ready = '1;
    bus.req_valid = '0;
    repeat (MUL_LAT + 2) step();

    // Reset with a full pipeline
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 100 + i, 7);
    bus.req_valid = '1;
    repeat (MUL_LAT + 1) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_busy",  32'(bus.busy),      32'h0);
    chk("t5_vld",   32'(bus.rsp_valid), 32'h0);
    chk("t5_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    repeat (MUL_LAT + 1) step();

    // Pointer at 2 with requesters 1 and 3 pending
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("t6_first", 32'(bus.req_ready), 32'h8);
    step();
    @(negedge clk);
    chk("t6_second", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = '0;
    repeat (MUL_LAT + 1) step();

    // Random traffic with backpressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      bus.req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        set_op(i, int'($urandom), int'($urandom));
        bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    repeat (MUL_LAT + 2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
